// File: rtl/poly_pkg.sv
// Shared constants and state encoding for the polynomial multiplier datapath.
package poly_pkg;

  localparam int N  = 4;
  localparam int W  = 1;
  localparam int M  = 2 * N - 1;
  localparam int IW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/poly_coeff_sel.sv
// Selects coefficient idx out of a packed M*W coefficient vector; out-of-range idx yields 0.
module poly_coeff_sel #(
  parameter int M  = 7,
  parameter int W  = 1,
  parameter int IW = 3
) (
  input  logic [M*W-1:0] vec,
  input  logic [IW-1:0]  idx,
  output logic [W-1:0]   coeff
);

  // One-hot AND-OR mux so no index can read past the vector.
  always_comb begin
    coeff = '0;
    for (int k = 0; k < M; k++) begin
      coeff = coeff | ({W{idx == IW'(k)}} & vec[k*W +: W]);
    end
  end

endmodule

// File: rtl/poly_result_unloader.sv
// Captures a finished product and streams its coefficients out, lowest degree first,
// over valid/ready; back-pressures the sequencer and flags dropped products.
module poly_result_unloader #(
  parameter int N  = 4,
  parameter int W  = 1,
  parameter int M  = 2 * N - 1,
  parameter int IW = (M > 1) ? $clog2(M) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [M*W-1:0] prod_in,
  input  logic           prod_valid,
  output logic           unl_ready,
  output logic [W-1:0]   coeff_out,
  output logic [IW-1:0]  coeff_idx,
  output logic           out_valid,
  output logic           out_last,
  input  logic           out_ready,
  output logic           overrun,
  input  logic           overrun_clr
);

  import poly_pkg::*;

  state_t         state_r;
  logic [M*W-1:0] shadow_r;
  logic [IW-1:0]  idx_r;
  logic           out_valid_r;
  logic           out_last_r;
  logic [W-1:0]   coeff_out_r;
  logic [IW-1:0]  coeff_idx_r;
  logic           overrun_r;

  logic           hs_s;
  logic           unl_ready_s;
  logic           accept_s;
  logic           overrun_set_s;
  logic [M*W-1:0] sel_vec_s;
  logic [IW-1:0]  sel_idx_s;
  logic [W-1:0]   coeff_next_s;

  // Handshake, acceptance and next-beat selection; a capture bypasses the shadow so idx 0 needs no bubble.
  always_comb begin
    hs_s          = out_valid_r && out_ready;
    unl_ready_s   = (state_r == IDLE) || (hs_s && out_last_r);
    accept_s      = prod_valid && unl_ready_s;
    overrun_set_s = prod_valid && !unl_ready_s;
    if (accept_s) begin
      sel_vec_s = prod_in;
      sel_idx_s = '0;
    end else begin
      sel_vec_s = shadow_r;
      sel_idx_s = idx_r + IW'(1);
    end
  end

  poly_coeff_sel #(
    .M  (M),
    .W  (W),
    .IW (IW)
  ) u_coeff_sel (
    .vec   (sel_vec_s),
    .idx   (sel_idx_s),
    .coeff (coeff_next_s)
  );

  // Sticky overrun flag; a new drop in the clearing cycle wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_r <= 1'b0;
    end else if (overrun_set_s) begin
      overrun_r <= 1'b1;
    end else if (overrun_clr) begin
      overrun_r <= 1'b0;
    end
  end

  // Unloader FSM with registered stream outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      shadow_r    <= '0;
      idx_r       <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      coeff_out_r <= '0;
      coeff_idx_r <= '0;
    end else if (accept_s) begin
      state_r     <= SEND;
      shadow_r    <= prod_in;
      idx_r       <= '0;
      out_valid_r <= 1'b1;
      out_last_r  <= (M == 1);
      coeff_out_r <= coeff_next_s;
      coeff_idx_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        SEND: begin
          if (hs_s && out_last_r) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            coeff_out_r <= '0;
            coeff_idx_r <= '0;
          end else if (hs_s) begin
            idx_r       <= sel_idx_s;
            out_last_r  <= (sel_idx_s == IW'(M - 1));
            coeff_out_r <= coeff_next_s;
            coeff_idx_r <= sel_idx_s;
          end
        end
        default: begin
          state_r     <= IDLE;
          idx_r       <= '0;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          coeff_out_r <= '0;
          coeff_idx_r <= '0;
        end
      endcase
    end
  end

  assign unl_ready = unl_ready_s;
  assign coeff_out = coeff_out_r;
  assign coeff_idx = coeff_idx_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_poly_result_unloader.sv
// Directed and random checks of poly_result_unloader against a queue-based stream model.
module tb_poly_result_unloader;

  localparam int MA = 7;
  localparam int MB = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        out_ready = 1'b0;
  logic        overrun_clr = 1'b0;

  logic [6:0]  prod_in_a = '0;
  logic        prod_valid_a = 1'b0;
  logic        unl_ready_a;
  logic [0:0]  coeff_a;
  logic [2:0]  idx_a;
  logic        valid_a, last_a, overrun_a;

  logic [11:0] prod_in_b = '0;
  logic        prod_valid_b = 1'b0;
  logic        unl_ready_b;
  logic [3:0]  coeff_b;
  logic [1:0]  idx_b;
  logic        valid_b, last_b, overrun_b;

  int errors = 0;
  int checks = 0;

  // Model: remaining beats of the product in flight, sticky overrun, handshake logs.
  int qa[$];
  int qb[$];
  int log_a[$];
  int log_b[$];
  bit ova = 1'b0;
  bit ovb = 1'b0;

  always #5 clk = ~clk;

  poly_result_unloader #(.N(4), .W(1)) u_dut_a (
    .clk(clk), .reset(reset), .prod_in(prod_in_a), .prod_valid(prod_valid_a),
    .unl_ready(unl_ready_a), .coeff_out(coeff_a), .coeff_idx(idx_a),
    .out_valid(valid_a), .out_last(last_a), .out_ready(out_ready),
    .overrun(overrun_a), .overrun_clr(overrun_clr)
  );

  poly_result_unloader #(.N(2), .W(4)) u_dut_b (
    .clk(clk), .reset(reset), .prod_in(prod_in_b), .prod_valid(prod_valid_b),
    .unl_ready(unl_ready_b), .coeff_out(coeff_b), .coeff_idx(idx_b),
    .out_valid(valid_b), .out_last(last_b), .out_ready(out_ready),
    .overrun(overrun_b), .overrun_clr(overrun_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs at negedge, check outputs, advance the model for the coming edge.
  task automatic step(input logic pv_a, input logic [6:0] p_a, input logic pv_b,
                      input logic [11:0] p_b, input logic ordy, input logic clr);
    bit rdy_a, rdy_b;
    @(negedge clk);
    prod_valid_a = pv_a; prod_in_a = p_a;
    prod_valid_b = pv_b; prod_in_b = p_b;
    out_ready = ordy; overrun_clr = clr;
    #1;
    rdy_a = (qa.size() == 0) || (ordy && qa.size() == 1);
    rdy_b = (qb.size() == 0) || (ordy && qb.size() == 1);
    chk("a_valid", valid_a, 32'(qa.size() > 0));
    chk("a_last", last_a, 32'(qa.size() == 1));
    chk("a_unl_ready", unl_ready_a, 32'(rdy_a));
    chk("a_overrun", overrun_a, 32'(ova));
    if (qa.size() > 0) begin
      chk("a_coeff", coeff_a, qa[0]);
      chk("a_idx", idx_a, MA - qa.size());
    end
    chk("b_valid", valid_b, 32'(qb.size() > 0));
    chk("b_last", last_b, 32'(qb.size() == 1));
    chk("b_unl_ready", unl_ready_b, 32'(rdy_b));
    chk("b_overrun", overrun_b, 32'(ovb));
    if (qb.size() > 0) begin
      chk("b_coeff", coeff_b, qb[0]);
      chk("b_idx", idx_b, MB - qb.size());
    end
    if (ordy && qa.size() > 0) log_a.push_back(qa.pop_front());
    if (ordy && qb.size() > 0) log_b.push_back(qb.pop_front());
    if (pv_a && rdy_a) begin
      for (int k = 0; k < MA; k++) qa.push_back(int'(p_a[k]));
    end
    if (pv_b && rdy_b) begin
      for (int k = 0; k < MB; k++) qb.push_back(int'(p_b[k*4 +: 4]));
    end
    if (pv_a && !rdy_a) ova = 1'b1;
    else if (clr) ova = 1'b0;
    if (pv_b && !rdy_b) ovb = 1'b1;
    else if (clr) ovb = 1'b0;
  endtask

  task automatic idle_steps(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 7'd0, 1'b0, 12'd0, ordy, 1'b0);
  endtask

  initial begin
    int exp_a[7];
    int exp_b[3];
    exp_a = '{0, 0, 1, 0, 1, 0, 0};
    exp_b = '{10, 5, 12};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_valid", valid_a, 32'd0);
    chk("rst_last", last_a, 32'd0);
    chk("rst_coeff", coeff_a, 32'd0);
    chk("rst_idx", idx_a, 32'd0);
    chk("rst_overrun", overrun_a, 32'd0);
    chk("rst_unl_ready", unl_ready_a, 32'd1);
    reset = 1'b1;

    // Full drain of x^4+x^2 with out_ready high
    log_a.delete();
    step(1'b1, 7'b0010100, 1'b0, 12'd0, 1'b1, 1'b0);
    idle_steps(8, 1'b1);
    chk("drain_count", log_a.size(), 32'd7);
    for (int i = 0; i < 7; i++) chk("drain_seq", (i < log_a.size()) ? log_a[i] : -1, exp_a[i]);

    // Same product with a stalling consumer
    log_a.delete();
    step(1'b1, 7'b0010100, 1'b0, 12'd0, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) step(1'b0, 7'd0, 1'b0, 12'd0, (i % 3) == 0, 1'b0);
    chk("stall_count", log_a.size(), 32'd7);
    for (int i = 0; i < 7; i++) chk("stall_seq", (i < log_a.size()) ? log_a[i] : -1, exp_a[i]);

    // Back-to-back capture on the final handshake
    step(1'b1, 7'b0010100, 1'b0, 12'd0, 1'b1, 1'b0);
    idle_steps(6, 1'b1);
    step(1'b1, 7'b1111111, 1'b0, 12'd0, 1'b1, 1'b0);
    chk("b2b_valid", valid_a, 32'd1);
    idle_steps(8, 1'b1);

    // Overrun at idx 3, clear, then clear coincident with a new drop
    step(1'b1, 7'b1010011, 1'b0, 12'd0, 1'b1, 1'b0);
    idle_steps(3, 1'b1);
    step(1'b1, 7'b0101100, 1'b0, 12'd0, 1'b1, 1'b0);
    idle_steps(4, 1'b1);
    chk("ovr_set", overrun_a, 32'd1);
    step(1'b0, 7'd0, 1'b0, 12'd0, 1'b1, 1'b1);
    step(1'b1, 7'b1100101, 1'b0, 12'd0, 1'b0, 1'b0);
    step(1'b1, 7'b0000001, 1'b0, 12'd0, 1'b0, 1'b1);
    step(1'b0, 7'd0, 1'b0, 12'd0, 1'b0, 1'b0);
    chk("ovr_set_wins", overrun_a, 32'd1);
    idle_steps(8, 1'b1);
    step(1'b0, 7'd0, 1'b0, 12'd0, 1'b1, 1'b1);

    // Asynchronous reset mid-drain at idx 2
    step(1'b1, 7'b1111111, 1'b0, 12'd0, 1'b1, 1'b0);
    idle_steps(2, 1'b1);
    @(negedge clk);
    prod_valid_a = 1'b0; prod_valid_b = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0;
    #1;
    chk("pre_rst_idx", idx_a, 32'd2);
    reset = 1'b0;
    #1;
    chk("arst_valid", valid_a, 32'd0);
    chk("arst_idx", idx_a, 32'd0);
    chk("arst_last", last_a, 32'd0);
    qa.delete(); qb.delete(); ova = 1'b0; ovb = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 7'b0110010, 1'b0, 12'd0, 1'b1, 1'b0);
    idle_steps(8, 1'b1);

    // Wide-coefficient instance
    log_b.delete();
    step(1'b0, 7'd0, 1'b1, {4'hC, 4'h5, 4'hA}, 1'b1, 1'b0);
    idle_steps(4, 1'b1);
    chk("w4_count", log_b.size(), 32'd3);
    for (int i = 0; i < 3; i++) chk("w4_seq", (i < log_b.size()) ? log_b[i] : -1, exp_b[i]);

    // Random traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 6) == 0, 7'($urandom), ($urandom % 4) == 0, 12'($urandom),
           ($urandom % 2) == 0, ($urandom % 10) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
